display_fetch: RTL and testbench
================================

DISPLAY_FETCH -- requirements
Module: display_fetch

Interface
REQ-001 SHALL have parameter WORDS_PER_FRAME, default 3201, meaning memory words per frame (word index 0..3200).
REQ-002 SHALL have parameter WORD_W, default 36, meaning memory word width.
REQ-003 SHALL have parameter PIX_W, default 3, meaning pixel width; WORD_W/PIX_W = 12 pixels per word.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning word buffer depth (power of 2).
REQ-005 i_clk  input  1  single clock, all logic on rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_enable  input  1  fetch enable; low stops new requests.
REQ-008 o_request  output  1  word request to image memory.
REQ-009 i_valor  input  WORD_W  word returned by memory.
REQ-010 o_pixel  output  PIX_W  current pixel.
REQ-011 o_pixel_valid  output  1  o_pixel is valid.
REQ-012 i_pixel_ready  input  1  display accepts pixel.
REQ-013 o_frame_start  output  1  marks first pixel of word 0.
REQ-014 o_frame_end  output  1  marks last pixel of word WORDS_PER_FRAME-1.
REQ-015 o_underrun  output  1  sticky: unpacker starved mid-frame.

Function
REQ-016 o_request SHALL be driven directly from a flop (no combinational path), since memory gates its clock with it.
REQ-017 o_request SHALL assert only when i_enable=1 and (FIFO occupancy + in-flight words) < FIFO_DEPTH; back-to-back cycles allowed.
REQ-018 Memory latency is fixed: word for a request high in cycle N SHALL be written into FIFO from i_valor in cycle N+1.
REQ-019 Each request SHALL advance a word counter 0..WORDS_PER_FRAME-1, wrapping 3200->0; the counter tracks memory's internal address.
REQ-020 Each FIFO entry SHALL carry a first-word flag (counter==0) and a last-word flag (counter==WORDS_PER_FRAME-1).
REQ-021 Unpacker FSM states: IDLE, LOAD, SHIFT.
REQ-022 IDLE->LOAD when FIFO not empty; LOAD pops one word into a WORD_W shift register, sets pixel index 0, -> SHIFT.
REQ-023 In SHIFT, o_pixel SHALL be word bits [WORD_W-1 -: PIX_W] of the shift register (MSB pixel first), o_pixel_valid=1.
REQ-024 A pixel transfers when o_pixel_valid & i_pixel_ready; o_pixel SHALL hold stable while valid & !ready.
REQ-025 On transfer of pixel index 11: if FIFO not empty, pop next word the same cycle (no bubble, stay SHIFT); else -> IDLE.
REQ-026 o_frame_start SHALL be 1 exactly while pixel index 0 of a first-word-flagged entry is presented.
REQ-027 o_frame_end SHALL be 1 exactly while pixel index 11 of a last-word-flagged entry is presented.
REQ-028 o_underrun SHALL set when unpacker enters IDLE after a word that is not last-flagged while i_enable=1; cleared only by reset.
REQ-029 Simultaneous FIFO push and pop SHALL both occur; occupancy unchanged.
REQ-030 FIFO SHALL never overflow (guaranteed by REQ-017); push into full FIFO is a design error flagged by assertion.
REQ-031 i_enable falling SHALL not drop in-flight words; buffered pixels continue draining.

Reset
REQ-032 On i_rst_n=0 asynchronously: o_request=0, o_pixel=0, o_pixel_valid=0, o_frame_start=0, o_frame_end=0, o_underrun=0, word counter=0, FIFO empty, in-flight=0, FSM=IDLE.
REQ-033 Reset mid-frame SHALL discard buffered words; after release, fetching restarts at word 0 (memory must be reset concurrently).
REQ-034 First o_request SHALL occur no earlier than the second rising edge after i_rst_n rises.

Verification
REQ-035 Ready held 1, enable 1, memory model word k = k: pixels emerge in order, 12 per word, o_frame_start on word 0 pixel 0, o_frame_end on word 3200 pixel 11, then word 0 again.
REQ-036 Word 36'hFFF000AAA: pixels 7,7,7,7,0,0,0,0,5,2,5,2 in that order.
REQ-037 i_pixel_ready held 0 for 50 cycles: o_pixel stable, o_request stops after 4 words outstanding, no FIFO overflow.
REQ-038 i_enable dropped mid-frame at word 100: no request after, pixels up to word 100+buffered drain, o_underrun=1.
REQ-039 Reset asserted during word 2000, released: all outputs 0 immediately; next o_frame_start precedes any other frame marker.
REQ-040 Ready toggling 1/0 each cycle: no pixel duplicated or lost across 2 frames (scoreboard vs memory model).

Source files
------------

// File: rtl/display_fetch.sv
// Display fetch engine: requests frame words from image memory, buffers them in a small FIFO
// and unpacks each word MSB-first into pixels for the display, marking frame boundaries.
`timescale 1ns/1ps
module display_fetch #(
   parameter int unsigned WORDS_PER_FRAME = 3201,
   parameter int unsigned WORD_W          = 36,
   parameter int unsigned PIX_W           = 3,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_enable,
   output logic              o_request,
   input  logic [WORD_W-1:0] i_valor,
   output logic [PIX_W-1:0]  o_pixel,
   output logic              o_pixel_valid,
   input  logic              i_pixel_ready,
   output logic              o_frame_start,
   output logic              o_frame_end,
   output logic              o_underrun
);

   localparam int unsigned PIX_PER_WORD = WORD_W / PIX_W;
   localparam int unsigned CNT_W        = $clog2(WORDS_PER_FRAME);
   localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
   localparam int unsigned IDX_W        = $clog2(PIX_PER_WORD);
   localparam int unsigned RESV_W       = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StShift} state_t;

   // Fetch side
   logic              r_start;
   logic              r_request, r_req_first, r_req_last;
   logic              r_push, r_push_first, r_push_last;
   logic [CNT_W-1:0]  r_word_cnt;
   logic [RESV_W-1:0] r_resv;
   logic [RESV_W-1:0] w_resv_after;
   logic              w_issue;

   // FIFO
   logic [WORD_W-1:0] r_mem       [FIFO_DEPTH];
   logic              r_mem_first [FIFO_DEPTH];
   logic              r_mem_last  [FIFO_DEPTH];
   logic [PTR_W:0]    r_wptr, r_rptr;
   logic [PTR_W:0]    w_count;
   logic              w_empty, w_full, w_pop;

   // Unpacker
   state_t            r_state;
   logic [WORD_W-1:0] r_shift;
   logic [IDX_W-1:0]  r_idx;
   logic              r_last, r_valid, r_fs, r_fe, r_underrun;
   logic              w_xfer, w_last_pix;

   // Reservations cover both buffered and in-flight words, so a request never overflows the FIFO.
   always_comb begin
      w_resv_after = r_resv - RESV_W'(w_pop);
      w_issue      = r_start && i_enable && (w_resv_after < RESV_W'(FIFO_DEPTH));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_start      <= 1'b0;
         r_request    <= 1'b0;
         r_req_first  <= 1'b0;
         r_req_last   <= 1'b0;
         r_push       <= 1'b0;
         r_push_first <= 1'b0;
         r_push_last  <= 1'b0;
         r_word_cnt   <= '0;
         r_resv       <= '0;
      end else begin
         r_start      <= 1'b1;
         r_request    <= w_issue;
         r_push       <= r_request;
         r_push_first <= r_req_first;
         r_push_last  <= r_req_last;
         r_resv       <= w_resv_after + RESV_W'(w_issue);
         if (w_issue) begin
            r_req_first <= (r_word_cnt == '0);
            r_req_last  <= (r_word_cnt == CNT_W'(WORDS_PER_FRAME - 1));
            r_word_cnt  <= (r_word_cnt == CNT_W'(WORDS_PER_FRAME - 1)) ? '0 : r_word_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_count = r_wptr - r_rptr;
      w_empty = (r_wptr == r_rptr);
      w_full  = (w_count == (PTR_W+1)'(FIFO_DEPTH));
   end

   always_ff @(posedge i_clk) begin
      if (r_push) begin
         r_mem[r_wptr[PTR_W-1:0]]       <= i_valor;
         r_mem_first[r_wptr[PTR_W-1:0]] <= r_push_first;
         r_mem_last[r_wptr[PTR_W-1:0]]  <= r_push_last;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (r_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   assert property (@(posedge i_clk) disable iff (!i_rst_n) !(r_push && w_full))
      else $error("display_fetch: push into full FIFO");

   always_comb begin
      w_xfer     = r_valid && i_pixel_ready;
      w_last_pix = (r_idx == IDX_W'(PIX_PER_WORD - 1));
      w_pop      = (r_state == StLoad) ||
                   (r_state == StShift && w_xfer && w_last_pix && !w_empty);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_shift    <= '0;
         r_idx      <= '0;
         r_last     <= 1'b0;
         r_valid    <= 1'b0;
         r_fs       <= 1'b0;
         r_fe       <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (!w_empty) r_state <= StLoad;
            end
            StLoad: begin
               r_shift <= r_mem[r_rptr[PTR_W-1:0]];
               r_last  <= r_mem_last[r_rptr[PTR_W-1:0]];
               r_fs    <= r_mem_first[r_rptr[PTR_W-1:0]];
               r_fe    <= 1'b0;
               r_idx   <= '0;
               r_valid <= 1'b1;
               r_state <= StShift;
            end
            StShift: begin
               if (w_xfer) begin
                  if (w_last_pix) begin
                     if (!w_empty) begin
                        // Back-to-back word: reload without a bubble.
                        r_shift <= r_mem[r_rptr[PTR_W-1:0]];
                        r_last  <= r_mem_last[r_rptr[PTR_W-1:0]];
                        r_fs    <= r_mem_first[r_rptr[PTR_W-1:0]];
                        r_fe    <= 1'b0;
                        r_idx   <= '0;
                     end else begin
                        r_state <= StIdle;
                        r_valid <= 1'b0;
                        r_fs    <= 1'b0;
                        r_fe    <= 1'b0;
                        if (!r_last && i_enable) r_underrun <= 1'b1;
                     end
                  end else begin
                     r_shift <= r_shift << PIX_W;
                     r_idx   <= r_idx + 1'b1;
                     r_fs    <= 1'b0;
                     r_fe    <= r_last && (r_idx == IDX_W'(PIX_PER_WORD - 2));
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_request     = r_request;
   assign o_pixel       = r_shift[WORD_W-1 -: PIX_W];
   assign o_pixel_valid = r_valid;
   assign o_frame_start = r_fs;
   assign o_frame_end   = r_fe;
   assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_display_fetch.sv
// Bench for display_fetch: memory model plus a pixel-sequence reference model, with directed
// phases for reset, stall, enable drop, underrun and mid-frame reset under randomized ready.
`timescale 1ns/1ps
module tb_display_fetch;
   localparam int WPF = 3201, WW = 36, PW = 3, DEPTH = 4, PPW = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0, enable = 1'b0, ready = 1'b1;
   logic          request, pv, fs, fe, underrun;
   logic [WW-1:0] valor;
   logic [PW-1:0] pixel;

   always #5 clk = ~clk;

   display_fetch #(
      .WORDS_PER_FRAME(WPF), .WORD_W(WW), .PIX_W(PW), .FIFO_DEPTH(DEPTH)
   ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .o_request(request),
      .i_valor(valor), .o_pixel(pixel), .o_pixel_valid(pv), .i_pixel_ready(ready),
      .o_frame_start(fs), .o_frame_end(fe), .o_underrun(underrun)
   );

   int n_checks = 0, n_fail = 0;
   int mode = 0, ready_mode = 0;
   int mem_addr, n_req;
   int exp_word = 0, exp_pix = 0, n_done = 0, n_fs = 0, n_fe = 0;
   int pres_pix, pres_done;
   bit capture = 1'b0;
   bit en_at_edge = 1'b0;
   logic [PW-1:0] q_pix[$];

   function automatic logic [WW-1:0] mem_word(int k);
      if (mode == 0) return WW'(k);
      if (k == 0) return 36'hFFF000AAA;
      return {12'(k), ~12'(k), 12'(k) ^ 12'h5A5};
   endfunction

   function automatic logic [PW-1:0] exp_px(int w, int p);
      logic [WW-1:0] d;
      d = mem_word(w);
      return d[WW-1-PW*p -: PW];
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Fixed-latency image memory: a request in cycle N is answered during cycle N+1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr <= 0;
         n_req    <= 0;
         valor    <= '0;
      end else if (request) begin
         valor    <= mem_word(mem_addr);
         mem_addr <= (mem_addr + 1) % WPF;
         n_req    <= n_req + 1;
      end
   end

   always @(posedge clk) en_at_edge <= enable;

   // Reference model: the pixel stream is word 0,1,2,... each split into 12 pixels MSB first.
   always @(negedge clk) begin
      if (rst_n) begin
         case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = 1'b0;
            2:       ready = ~ready;
            default: ready = 1'($urandom_range(0, 1));
         endcase
         pres_pix  = exp_pix;
         pres_done = n_done;
         chk("frame_start", fs, pv && exp_word == 0 && exp_pix == 0);
         chk("frame_end", fe, pv && exp_word == WPF - 1 && exp_pix == PPW - 1);
         if (pv) chk("pixel", pixel, exp_px(exp_word, exp_pix));
         if (request) chk("req_budget", (n_req + 1 - n_done - int'(pv)) <= DEPTH, 1);
         if (!en_at_edge) chk("req_while_disabled", request, 0);
         if (pv && ready) begin
            if (fs) n_fs++;
            if (fe) n_fe++;
            if (capture && q_pix.size() < PPW) q_pix.push_back(pixel);
            exp_pix++;
            if (exp_pix == PPW) begin
               exp_pix  = 0;
               n_done++;
               exp_word = (exp_word + 1) % WPF;
            end
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_request"}, request, 0);
      chk({tag, "_pixel"}, pixel, 0);
      chk({tag, "_valid"}, pv, 0);
      chk({tag, "_fs"}, fs, 0);
      chk({tag, "_fe"}, fe, 0);
      chk({tag, "_underrun"}, underrun, 0);
   endtask

   task automatic model_reset();
      exp_word = 0; exp_pix = 0; n_done = 0; n_fs = 0; n_fe = 0;
   endtask

   initial begin
      logic [PW-1:0] exp36 [PPW];
      int stall_req, req_at_drop, i;
      exp36 = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd2, 3'd5, 3'd2};

      // Reset state, then sequential frame with word k = k
      repeat (3) step();
      chk_all_zero("reset");
      enable = 1'b1;
      rst_n  = 1'b1;
      @(posedge clk); #1;
      chk("first_edge_no_request", request, 0);

      for (i = 0; i < 500 && n_done < 10; i++) step();
      chk("reach_word10", n_done >= 10, 1);
      ready_mode = 1;
      repeat (10) step();
      stall_req = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (request) stall_req++;
      end
      chk("stall_requests", stall_req, 0);
      chk("stall_valid", pv, 1);
      ready_mode = 0;
      for (i = 0; i < 45000 && n_done < WPF + 2; i++) step();
      chk("frame_wrapped", n_done >= WPF + 2, 1);
      chk("frame_start_count", n_fs, 2);
      chk("frame_end_count", n_fe, 1);
      chk("no_underrun_streaming", underrun, 0);

      // Mid-frame reset; new content with 36'hFFF000AAA at word 0, randomized ready
      rst_n = 1'b0;
      #1;
      chk_all_zero("reset2");
      model_reset();
      mode = 1;
      capture = 1'b1;
      q_pix.delete();
      ready_mode = 3;
      repeat (3) step();
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("first_edge_no_request2", request, 0);
      for (i = 0; i < 2000 && q_pix.size() < PPW; i++) step();
      chk("word0_captured", q_pix.size(), PPW);
      for (int k = 0; k < PPW; k++) chk($sformatf("word0_px%0d", k), q_pix[k], exp36[k]);

      // Enable dropped at word 100: buffered words drain, then re-enable on the final pixel
      for (i = 0; i < 10000 && exp_word != 100; i++) step();
      chk("reach_word100", exp_word, 100);
      enable = 1'b0;
      ready_mode = 0;
      step(); step();
      req_at_drop = n_req;
      for (i = 0; i < 200 && !(pv && pres_pix == PPW - 1 && pres_done == n_req - 1); i++) step();
      chk("drain_last_pixel", pv && pres_pix == PPW - 1 && pres_done == n_req - 1, 1);
      chk("no_request_after_drop", n_req, req_at_drop);
      chk("drained_past_word100", n_req > 100, 1);
      chk("underrun_before_starve", underrun, 0);
      enable = 1'b1;
      repeat (4) step();
      chk("underrun_set", underrun, 1);

      // Reset during word 2000; first marker afterwards must be a frame start
      for (i = 0; i < 30000 && !(exp_word == 2000 && exp_pix == 5); i++) step();
      chk("reach_word2000", exp_word, 2000);
      rst_n = 1'b0;
      #1;
      chk_all_zero("reset3");
      model_reset();
      capture = 1'b0;
      ready_mode = 2;
      step(); step();
      rst_n = 1'b1;
      for (i = 0; i < 400 && n_done < 3; i++) step();
      chk("restart_words", n_done >= 3, 1);
      chk("restart_fs_count", n_fs, 1);
      chk("restart_fe_count", n_fe, 0);
      chk("restart_underrun_clear", underrun, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
